// File: rtl/ttl_logic_pkg.sv
// ttl_logic_pkg: shared definitions for the TTL-replacement logic blocks.
//   phase_e : nibble-pairing phase (ST_IDLE awaits the A/low nibble,
//             ST_HAVE_A holds it while waiting for the B/high nibble)
//   clog2   : elaboration-time ceiling log2 for pointer/count widths
package ttl_logic_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_HAVE_A = 1'b1
   } phase_e;

   // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(4) = 2.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ls157_demux_fifo.sv
// ls157_demux_fifo: small synchronous FIFO for rebuilt words, registered head.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write wdata this edge (dropped if full and not popping)
//   pop        : read head this edge (ignored while empty)
//   wdata      : word to enqueue
//   q          : registered head word, 0 when empty
//   valid      : registered non-empty flag
//   count      : registered occupancy
//   drop_c     : combinational, push is being discarded this cycle
module ls157_demux_fifo
   import ttl_logic_pkg::*;
#(
   parameter int unsigned W2    = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [W2-1:0]         wdata,
   output logic [W2-1:0]         q,
   output logic                  valid,
   output logic [clog2(DEPTH):0] count,
   output logic                  drop_c
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W2-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_nxt;
   logic [AW-1:0] wr_nxt;
   logic [CW-1:0] count_nxt;
   logic [CW-1:0] remain_c;
   logic [W2-1:0] q_nxt;
   logic          full_c;
   logic          pop_eff;
   logic          push_eff;

   // Pop/push qualification; a full FIFO still accepts a push when popping.
   always_comb begin
      full_c   = (count == CW'(DEPTH));
      pop_eff  = pop & valid;
      push_eff = push & (~full_c | pop_eff);
      drop_c   = push & full_c & ~pop_eff;
   end

   // Next pointers, occupancy and head word.
   always_comb begin
      rd_nxt    = rd_ptr;
      wr_nxt    = wr_ptr;
      q_nxt     = '0;
      if (pop_eff)  rd_nxt = AW'(rd_ptr + AW'(1));
      if (push_eff) wr_nxt = AW'(wr_ptr + AW'(1));
      remain_c  = CW'(count - CW'(pop_eff));
      count_nxt = CW'(remain_c + CW'(push_eff));
      // If nothing survives the pop, the new head is the word being written now.
      if (count_nxt == '0)
         q_nxt = '0;
      else if (remain_c == '0)
         q_nxt = wdata;
      else
         q_nxt = mem[rd_nxt];
   end

   // Pointer, count and head registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         q      <= '0;
         valid  <= 1'b0;
      end else begin
         rd_ptr <= rd_nxt;
         wr_ptr <= wr_nxt;
         count  <= count_nxt;
         q      <= q_nxt;
         valid  <= (count_nxt != '0);
      end
   end

   // Storage needs no reset: the head register is gated by occupancy.
   always_ff @(posedge clk) begin
      if (push_eff) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ls157_nibble_demux.sv
// ls157_nibble_demux: rebuilds 2*W-bit words from an ls157-style time-muxed
// nibble bus (A = low nibble, B = high nibble) and queues them.
//   CLK    : clock
//   RST    : synchronous active-high reset
//   nG     : active-low strobe; D/nSELA sampled only when low
//   nSELA  : phase tag, 0 = A (low), 1 = B (high)
//   D      : nibble bus
//   Q      : FIFO head {B,A}, 0 when empty
//   VALID  : FIFO non-empty
//   READY  : consumer accepts Q on VALID&READY
//   COUNT  : FIFO occupancy
//   ERR    : 1-cycle pulse on phase sequence violation
//   OVF    : 1-cycle pulse when a completed word is dropped (FIFO full)
module ls157_nibble_demux
   import ttl_logic_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  nG,
   input  logic                  nSELA,
   input  logic [W-1:0]          D,
   output logic [2*W-1:0]        Q,
   output logic                  VALID,
   input  logic                  READY,
   output logic [clog2(DEPTH):0] COUNT,
   output logic                  ERR,
   output logic                  OVF
);

   phase_e         state;
   phase_e         state_nxt;
   logic [W-1:0]   lo;
   logic [W-1:0]   lo_nxt;
   logic           push_c;
   logic           err_nxt;
   logic           drop_c;
   logic [2*W-1:0] word_c;

   // Phase FSM: pair an A sample with the next B sample.
   always_comb begin
      state_nxt = state;
      lo_nxt    = lo;
      push_c    = 1'b0;
      err_nxt   = 1'b0;
      if (!nG) begin
         case (state)
            ST_IDLE: begin
               if (!nSELA) begin
                  lo_nxt    = D;
                  state_nxt = ST_HAVE_A;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            ST_HAVE_A: begin
               if (!nSELA) begin
                  // Repeated A: latest nibble wins, flag the glitch.
                  lo_nxt  = D;
                  err_nxt = 1'b1;
               end else begin
                  push_c    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign word_c = {D, lo};

   // FSM state, A-hold register and status pulses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         lo    <= '0;
         ERR   <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         state <= state_nxt;
         lo    <= lo_nxt;
         ERR   <= err_nxt;
         OVF   <= drop_c;
      end
   end

   ls157_demux_fifo #(
      .W2    (2*W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (CLK),
      .rst    (RST),
      .push   (push_c),
      .pop    (READY),
      .wdata  (word_c),
      .q      (Q),
      .valid  (VALID),
      .count  (COUNT),
      .drop_c (drop_c)
   );

endmodule

// File: tb/tb_ls157_nibble_demux.sv
// tb_ls157_nibble_demux: directed vectors with a queue-based reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_ls157_nibble_demux;

   logic       CLK;
   logic       RST;
   logic       nG;
   logic       nSELA;
   logic [3:0] D;
   logic [7:0] Q;
   logic       VALID;
   logic       READY;
   logic [1:0] COUNT;
   logic       ERR;
   logic       OVF;

   int n_vec;
   int n_err;
   bit chk_en;

   // Reference model state
   logic [7:0] mq[$];
   bit         m_have_a;
   logic [3:0] m_lo;
   bit         m_err;
   bit         m_ovf;

   ls157_nibble_demux #(.W(4), .DEPTH(2)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .nG    (nG),
      .nSELA (nSELA),
      .D     (D),
      .Q     (Q),
      .VALID (VALID),
      .READY (READY),
      .COUNT (COUNT),
      .ERR   (ERR),
      .OVF   (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: words complete on A-then-B; pop precedes push so a full queue
   // that is being drained still accepts the new word.
   always @(posedge CLK) begin
      bit         pop;
      bit         push;
      logic [7:0] w;
      if (RST) begin
         mq.delete();
         m_have_a = 0;
         m_lo     = '0;
         m_err    = 0;
         m_ovf    = 0;
      end else begin
         pop   = (mq.size() > 0) && READY;
         push  = 0;
         w     = '0;
         m_err = 0;
         m_ovf = 0;
         if (!nG) begin
            if (!nSELA) begin
               if (m_have_a) m_err = 1;
               m_lo     = D;
               m_have_a = 1;
            end else if (m_have_a) begin
               push     = 1;
               w        = {D, m_lo};
               m_have_a = 0;
            end else begin
               m_err = 1;
            end
         end
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < 2) mq.push_back(w);
            else m_ovf = 1;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("model_Q",     32'(Q),     (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
         check("model_VALID", 32'(VALID), 32'(mq.size() > 0));
         check("model_COUNT", 32'(COUNT), 32'(mq.size()));
         check("model_ERR",   32'(ERR),   32'(m_err));
         check("model_OVF",   32'(OVF),   32'(m_ovf));
      end
   end

   task automatic cyc(input bit ng, input bit sela, input logic [3:0] d, input bit rdy);
      nG    = ng;
      nSELA = sela;
      D     = d;
      READY = rdy;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      chk_en = 0;
      RST    = 1'b1;
      nG     = 1'b1;
      nSELA  = 1'b0;
      D      = '0;
      READY  = 1'b0;
      cyc(1, 0, 0, 0);
      chk_en = 1;
      cyc(1, 0, 0, 0);
      RST = 1'b0;
      check("reset_VALID", 32'(VALID), 32'd0);
      check("reset_COUNT", 32'(COUNT), 32'd0);

      // 1: reset mid-pair with one word queued
      cyc(0, 0, 4'h1, 0);
      cyc(0, 1, 4'h2, 0);
      cyc(0, 0, 4'h6, 0);
      check("t1_pre_COUNT", 32'(COUNT), 32'd1);
      RST = 1'b1;
      cyc(1, 0, 0, 0);
      RST = 1'b0;
      check("t1_Q",     32'(Q),     32'h00);
      check("t1_VALID", 32'(VALID), 32'd0);
      check("t1_COUNT", 32'(COUNT), 32'd0);
      cyc(0, 1, 4'h5, 0);
      check("t1_ERR",   32'(ERR),   32'd1);
      check("t1_nopush", 32'(COUNT), 32'd0);
      cyc(1, 0, 0, 0);
      check("t1_ERR_end", 32'(ERR), 32'd0);

      // 2: basic pair then pop
      cyc(0, 0, 4'h3, 0);
      cyc(0, 1, 4'hA, 0);
      check("t2_Q",     32'(Q),     32'hA3);
      check("t2_VALID", 32'(VALID), 32'd1);
      cyc(1, 0, 0, 1);
      check("t2_popped", 32'(VALID), 32'd0);

      // 3: gapped phases
      cyc(0, 0, 4'h1, 0);
      repeat (10) cyc(1, 1, 4'hC, 0);
      cyc(0, 1, 4'hF, 0);
      check("t3_Q",   32'(Q),   32'hF1);
      check("t3_ERR", 32'(ERR), 32'd0);
      cyc(1, 0, 0, 1);

      // 4: sequence errors
      cyc(0, 1, 4'h7, 0);
      check("t4_ERR",   32'(ERR),   32'd1);
      check("t4_COUNT", 32'(COUNT), 32'd0);
      cyc(0, 0, 4'h2, 0);
      check("t4_ERR_off", 32'(ERR), 32'd0);
      cyc(0, 0, 4'h4, 0);
      check("t4_ERR_AA", 32'(ERR), 32'd1);
      cyc(0, 1, 4'h9, 0);
      check("t4_Q", 32'(Q), 32'h94);
      cyc(1, 0, 0, 1);

      // 5: overflow
      cyc(0, 0, 4'h1, 0);
      cyc(0, 1, 4'h2, 0);
      cyc(0, 0, 4'h3, 0);
      cyc(0, 1, 4'h4, 0);
      check("t5_COUNT_full", 32'(COUNT), 32'd2);
      cyc(0, 0, 4'h5, 0);
      cyc(0, 1, 4'h6, 0);
      check("t5_OVF",   32'(OVF),   32'd1);
      check("t5_COUNT", 32'(COUNT), 32'd2);
      cyc(1, 0, 0, 0);
      check("t5_OVF_off", 32'(OVF), 32'd0);
      check("t5_head0",   32'(Q),   32'h21);
      cyc(1, 0, 0, 1);
      check("t5_head1",   32'(Q),   32'h43);
      cyc(1, 0, 0, 1);
      check("t5_empty",   32'(VALID), 32'd0);

      // 6: full with simultaneous push and pop
      cyc(0, 0, 4'h1, 0);
      cyc(0, 1, 4'h2, 0);
      cyc(0, 0, 4'h3, 0);
      cyc(0, 1, 4'h4, 0);
      cyc(0, 0, 4'h5, 0);
      cyc(0, 1, 4'h6, 1);
      check("t6_OVF",   32'(OVF),   32'd0);
      check("t6_COUNT", 32'(COUNT), 32'd2);
      check("t6_Q",     32'(Q),     32'h43);
      cyc(1, 0, 0, 1);
      check("t6_Q2",    32'(Q),     32'h65);
      cyc(1, 0, 0, 1);
      check("t6_empty", 32'(VALID), 32'd0);
      cyc(1, 0, 0, 0);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
